// File: rtl/led_breathe_driver.sv
// PWM drive for the four board LEDs: off, full-on, fixed-duty and a breathing ramp
// (even LEDs in phase, odd LEDs in anti-phase). All LED outputs are registered.
module led_breathe_driver #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 390625,
  parameter int unsigned HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty_in,
  output logic [3:0]          led,
  output logic [PWM_BITS-1:0] level,
  output logic                period_start
);

  localparam int unsigned PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_BREATHE = 2'b01;
  localparam logic [1:0] MODE_ON      = 2'b10;

  typedef enum logic [1:0] {RISE, TOP, FALL, BOTTOM} state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_led [4];
  logic [PRE_W-1:0]    prescaler;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [1:0]          mode_q;
  logic                step_tick;
  logic                boundary;
  logic [3:0]          led_d;

  assign step_tick = (prescaler == PRE_W'(STEP_DIV - 1));
  assign boundary  = enable && (pwm_cnt == MAX);

  // Breathe state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RISE;
    else        state_q <= state_d;
  end

  // Breathe next-state: advances only on a step tick while breathing
  always_comb begin
    state_d = state_q;
    level_d = level;
    hold_d  = hold_cnt;
    if (enable && step_tick && (mode_q == MODE_BREATHE)) begin
      case (state_q)
        RISE: begin
          level_d = level + 1'b1;
          if (level == MAX - 1'b1) begin
            hold_d  = '0;
            state_d = TOP;
          end
        end
        TOP: begin
          if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) state_d = FALL;
          else                                     hold_d  = hold_cnt + 1'b1;
        end
        FALL: begin
          level_d = level - 1'b1;
          if (level == PWM_BITS'(1)) begin
            hold_d  = '0;
            state_d = BOTTOM;
          end
        end
        default: begin
          if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) state_d = RISE;
          else                                     hold_d  = hold_cnt + 1'b1;
        end
      endcase
    end
  end

  // PWM compare; fixed duty shares duty_q, breathe uses per-LED duty
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 4; i++) begin
      case (mode_q)
        MODE_OFF:     led_d[i] = 1'b0;
        MODE_ON:      led_d[i] = 1'b1;
        MODE_BREATHE: led_d[i] = (pwm_cnt < duty_led[i]);
        default:      led_d[i] = (pwm_cnt < duty_q);
      endcase
    end
  end

  // Counters, boundary-sampled controls and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      prescaler    <= '0;
      hold_cnt     <= '0;
      level        <= '0;
      mode_q       <= MODE_OFF;
      duty_q       <= '0;
      led          <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < 4; i++) duty_led[i] <= '0;
    end else if (!enable) begin
      led          <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      prescaler    <= step_tick ? '0 : prescaler + 1'b1;
      hold_cnt     <= hold_d;
      level        <= level_d;
      led          <= led_d;
      period_start <= (pwm_cnt == '0);
      // Reload uses the pre-update level so a coincident step lands next period
      if (boundary) begin
        mode_q <= mode;
        duty_q <= duty_in;
        for (int i = 0; i < 4; i++)
          duty_led[i] <= (i % 2 == 1) ? MAX - level : level;
      end
    end
  end

endmodule

// File: tb/tb_led_breathe_driver.sv
// Directed bench for led_breathe_driver with a cycle model feeding a scoreboard queue.
module tb_led_breathe_driver;

  localparam int unsigned PWM_BITS   = 4;
  localparam int unsigned STEP_DIV   = 2;
  localparam int unsigned HOLD_STEPS = 2;
  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] duty_in = 4'd0;
  logic [3:0] led;
  logic [3:0] level;
  logic       period_start;

  led_breathe_driver #(
    .PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .duty_in(duty_in),
    .led(led), .level(level), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    logic [3:0] level;
    logic       ps;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model state (0 RISE, 1 TOP, 2 FALL, 3 BOTTOM)
  int m_pwm, m_pre, m_st, m_hold, m_level, m_mode_q, m_duty_q;
  int m_duty [4];
  logic [3:0] m_led;
  logic m_ps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pwm = 0; m_pre = 0; m_st = 0; m_hold = 0; m_level = 0;
    m_mode_q = 0; m_duty_q = 0; m_led = 4'b0; m_ps = 1'b0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
  endtask

  task automatic model_step();
    int  old_level;
    bit  bnd, stk;
    if (!rst_n) begin model_reset(); return; end
    if (!enable) begin m_led = 4'b0; m_ps = 1'b0; return; end
    bnd = (m_pwm == MAXV);
    stk = (m_pre == STEP_DIV - 1);
    old_level = m_level;
    for (int i = 0; i < 4; i++) begin
      case (m_mode_q)
        0:       m_led[i] = 1'b0;
        2:       m_led[i] = 1'b1;
        1:       m_led[i] = (m_pwm < m_duty[i]);
        default: m_led[i] = (m_pwm < m_duty_q);
      endcase
    end
    m_ps = (m_pwm == 0);
    if (stk && m_mode_q == 1) begin
      case (m_st)
        0: begin m_level++; if (m_level == MAXV) begin m_st = 1; m_hold = 0; end end
        1: begin if (m_hold == HOLD_STEPS - 1) m_st = 2; else m_hold++; end
        2: begin m_level--; if (m_level == 0) begin m_st = 3; m_hold = 0; end end
        default: begin if (m_hold == HOLD_STEPS - 1) m_st = 0; else m_hold++; end
      endcase
    end
    if (bnd) begin
      m_mode_q = int'(mode);
      m_duty_q = int'(duty_in);
      for (int i = 0; i < 4; i++) m_duty[i] = (i % 2 == 0) ? old_level : MAXV - old_level;
    end
    m_pwm = (m_pwm + 1) % (MAXV + 1);
    m_pre = (m_pre + 1) % STEP_DIV;
  endtask

  // One clock: model predicts at the edge, DUT compared 1 time unit later
  task automatic tick();
    exp_t e, got;
    @(posedge clk);
    model_step();
    e.led = m_led; e.level = 4'(m_level); e.ps = m_ps;
    sbq.push_back(e);
    #1;
    got = sbq.pop_front();
    chk("led", 32'(led), 32'(got.led));
    chk("level", 32'(level), 32'(got.level));
    chk("period_start", 32'(period_start), 32'(got.ps));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Align to pwm_cnt == 0, then count high clocks of led[0]/led[1] over one period
  task automatic count_period(output int h0, output int h1);
    int guard = 0;
    while (m_pwm != 0 && guard < 40) begin tick(); guard++; end
    h0 = 0; h1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      h0 += int'(led[0]);
      h1 += int'(led[1]);
    end
  endtask

  initial begin
    int h0, h1, guard;
    int duties [3] = '{5, 0, 15};
    model_reset();

    // Reset held with mode=10: outputs stay low
    mode = 2'b10;
    ticks(5);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_level", 32'(level), 32'h0);
    rst_n = 1'b1;
    ticks(16);
    chk("first_period_off", 32'(led), 32'h0);
    tick();
    chk("first_on", 32'(led), 32'hF);

    // Fixed duty; second period after each change reflects the new duty
    mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      duty_in = 4'(duties[k]);
      count_period(h0, h1);
      count_period(h0, h1);
      chk("fixed_duty_led0", 32'(h0), 32'(duties[k]));
      chk("fixed_duty_led1", 32'(h1), 32'(duties[k]));
    end

    // Mid-period duty change takes effect only at the next period
    duty_in = 4'd5;
    count_period(h0, h1);
    h0 = 0;
    for (int i = 0; i < 3; i++) begin tick(); h0 += int'(led[0]); end
    duty_in = 4'd12;
    for (int i = 0; i < 13; i++) begin tick(); h0 += int'(led[0]); end
    chk("glitch_cur_period", 32'(h0), 32'd5);
    count_period(h0, h1);
    chk("glitch_next_period", 32'(h0), 32'd12);

    // Breathe from reset
    rst_n = 1'b0;
    mode = 2'b01;
    ticks(2);
    rst_n = 1'b1;
    count_period(h0, h1);
    chk("breathe_first_off", 32'(h0 + h1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      count_period(h0, h1);
      chk("breathe_complement", 32'(h0 + h1), 32'd15);
    end

    // Freeze mid-RISE at level 7
    guard = 0;
    while (!(m_level == 7 && m_st == 0) && guard < 300) begin tick(); guard++; end
    chk("reach_rise7", 32'(guard < 300), 32'd1);
    enable = 1'b0;
    tick();
    chk("freeze_led", 32'(led), 32'h0);
    ticks(9);
    chk("freeze_level", 32'(level), 32'd7);
    enable = 1'b1;
    ticks(40);

    // Asynchronous reset in FALL at level 9
    guard = 0;
    while (!(m_level == 9 && m_st == 2) && guard < 300) begin tick(); guard++; end
    chk("reach_fall9", 32'(guard < 300), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_led", 32'(led), 32'h0);
    chk("async_level", 32'(level), 32'h0);
    chk("async_ps", 32'(period_start), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
